// File: rtl/line_buf_ring_ctrl_pkg.sv
// Shared types and helpers for the line-buffer ring controller.
package line_buf_ring_pkg;

   typedef enum logic [1:0] { FILL, WAIT, READ, FLUSH } ring_state_t;

   // Width of an index able to address n entries (at least one bit).
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/line_buf_ring_ctrl_if.sv
// Control-side bundle between the ring controller and its environment
// (input splitter handshakes on one side, line_buf bank on the other).
interface line_buf_ring_ctrl_if
   import line_buf_ring_pkg::*;
#(
   parameter int LINES_AMOUNT = 3,
   parameter int IDX_WIDTH    = idx_width(LINES_AMOUNT)
);

   logic                    in_sof_i;
   logic                    in_eol_i;
   logic                    out_ready_i;
   logic                    out_eol_i;
   logic [LINES_AMOUNT-1:0] empty_i;
   logic [LINES_AMOUNT-1:0] wr_sel_o;
   logic [LINES_AMOUNT-1:0] pop_line_o;
   logic [LINES_AMOUNT-1:0] flush_line_o;
   logic [IDX_WIDTH-1:0]    oldest_idx_o;
   logic                    window_busy_o;

   modport slave (
      input  in_sof_i, in_eol_i, out_ready_i, out_eol_i, empty_i,
      output wr_sel_o, pop_line_o, flush_line_o, oldest_idx_o, window_busy_o
   );

   modport master (
      output in_sof_i, in_eol_i, out_ready_i, out_eol_i, empty_i,
      input  wr_sel_o, pop_line_o, flush_line_o, oldest_idx_o, window_busy_o
   );

endinterface

// File: rtl/line_buf_ring_ctrl_onehot_rot.sv
// One-hot rotator: synchronous load to 'b1, then optional rotate-left by one.
// Load and enable together yield 'b10 (load first, then rotate).
module ring_onehot_rot #(
   parameter int WIDTH = 3
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_load,
   input  logic             i_en,
   output logic [WIDTH-1:0] o_onehot
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0] r_onehot;
   logic [WIDTH-1:0] w_base;

   assign w_base = i_load ? ONE : r_onehot;

   always_ff @(posedge i_clk) begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      if (i_rst)
         r_onehot <= ONE;
      else if (i_load || i_en)
         r_onehot <= i_en ? {w_base[WIDTH-2:0], w_base[WIDTH-1]} : w_base;
   end

   assign o_onehot = r_onehot;

endmodule

// File: rtl/line_buf_ring_ctrl.sv
// Sequences a ring of line buffers into a sliding vertical window (control only).
// Optional statistics (lines_popped_o, stall_o) under `define LINE_BUF_RING_CTRL_STAT_EN.
module line_buf_ring_ctrl
   import line_buf_ring_pkg::*;
#(
   parameter int LINES_AMOUNT = 3,
   parameter int IDX_WIDTH    = idx_width(LINES_AMOUNT),
   parameter int CNT_WIDTH    = idx_width(LINES_AMOUNT + 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   line_buf_ring_ctrl_if.slave   ring
`ifdef LINE_BUF_RING_CTRL_STAT_EN
   ,
   output logic [15:0]           lines_popped_o,
   output logic                  stall_o
`endif
);

   localparam logic [CNT_WIDTH-1:0] FILL_LAST = CNT_WIDTH'(LINES_AMOUNT - 1);
   localparam logic [IDX_WIDTH-1:0] IDX_LAST  = IDX_WIDTH'(LINES_AMOUNT - 1);

   ring_state_t             r_state;
   logic [CNT_WIDTH-1:0]    r_fill_cnt;
   logic                    r_pending;
   logic [IDX_WIDTH-1:0]    r_oldest_idx;
   logic [LINES_AMOUNT-1:0] r_pop_line;
   logic [LINES_AMOUNT-1:0] r_flush_line;
   logic                    r_window_busy;

   logic [LINES_AMOUNT-1:0] w_wr_sel;
   logic [LINES_AMOUNT-1:0] w_oldest_onehot;
   logic                    w_pop_go;
   logic                    w_oldest_adv;

   assign w_pop_go     = (r_state == WAIT) && r_pending && ring.out_ready_i
                         && (ring.empty_i == '0);
   // SOF reloads the oldest pointer, so it must not also advance it.
   assign w_oldest_adv = (r_state == FLUSH) && !ring.in_sof_i;

   ring_onehot_rot #(.WIDTH(LINES_AMOUNT)) u_wr_sel_rot (
      .i_clk    (clk_i),
      .i_rst    (rst_i),
      .i_load   (ring.in_sof_i),
      .i_en     (ring.in_eol_i),
      .o_onehot (w_wr_sel)
   );

   ring_onehot_rot #(.WIDTH(LINES_AMOUNT)) u_oldest_rot (
      .i_clk    (clk_i),
      .i_rst    (rst_i),
      .i_load   (ring.in_sof_i),
      .i_en     (w_oldest_adv),
      .o_onehot (w_oldest_onehot)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state       <= FILL;
         r_fill_cnt    <= '0;
         r_pending     <= 1'b0;
         r_oldest_idx  <= '0;
         r_pop_line    <= '0;
         r_flush_line  <= '0;
         r_window_busy <= 1'b0;
      end else if (ring.in_sof_i) begin
         // A same-cycle eol is the first line of the new frame.
         r_state       <= FILL;
         r_fill_cnt    <= ring.in_eol_i ? CNT_WIDTH'(1) : '0;
         r_pending     <= ring.in_eol_i;
         r_oldest_idx  <= '0;
         r_pop_line    <= '0;
         r_flush_line  <= '0;
         r_window_busy <= 1'b0;
      end else begin
         r_pop_line   <= '0;
         r_flush_line <= '0;

         // A freshly completed line outranks the clear from a same-cycle pop.
         if (ring.in_eol_i)
            r_pending <= 1'b1;
         else if (w_pop_go)
            r_pending <= 1'b0;

         case (r_state)
            FILL: begin
               if (ring.in_eol_i) begin
                  r_fill_cnt <= r_fill_cnt + 1'b1;
                  if (r_fill_cnt == FILL_LAST)
                     r_state <= WAIT;
               end
            end
            WAIT: begin
               if (w_pop_go) begin
                  r_pop_line    <= '1;
                  r_window_busy <= 1'b1;
                  r_state       <= READ;
               end
            end
            READ: begin
               if (ring.out_eol_i) begin
                  r_flush_line  <= w_oldest_onehot;
                  r_window_busy <= 1'b0;
                  r_state       <= FLUSH;
               end
            end
            FLUSH: begin
               r_oldest_idx <= (r_oldest_idx == IDX_LAST) ? '0 : r_oldest_idx + 1'b1;
               r_state      <= WAIT;
            end
            default: r_state <= FILL;
         endcase
      end
   end

   assign ring.wr_sel_o      = w_wr_sel;
   assign ring.pop_line_o    = r_pop_line;
   assign ring.flush_line_o  = r_flush_line;
   assign ring.oldest_idx_o  = r_oldest_idx;
   assign ring.window_busy_o = r_window_busy;

`ifdef LINE_BUF_RING_CTRL_STAT_EN
   logic [15:0] r_lines_popped;

   always_ff @(posedge clk_i) begin
      if (rst_i || ring.in_sof_i)
         r_lines_popped <= '0;
      else if (w_pop_go && (r_lines_popped != 16'hFFFF))
         r_lines_popped <= r_lines_popped + 1'b1;
   end

   assign lines_popped_o = r_lines_popped;
   assign stall_o        = (r_state == WAIT) && r_pending && !ring.out_ready_i;
`endif

endmodule

// File: tb/tb_line_buf_ring_ctrl.sv
// Self-checking bench for line_buf_ring_ctrl: directed scenarios followed by
// random stimulus, all compared cycle by cycle against a line-counting model.
module tb_line_buf_ring_ctrl;

   localparam int N       = 3;
   localparam int IW      = 2;
   localparam int LINE_PX = 8;
   localparam int ALL1    = (1 << N) - 1;

   logic clk = 1'b0;
   logic rst;

   int n_vec = 0;
   int n_err = 0;

   line_buf_ring_ctrl_if #(.LINES_AMOUNT(N), .IDX_WIDTH(IW)) bus ();

`ifdef LINE_BUF_RING_CTRL_STAT_EN
   logic [15:0] lines_popped;
   logic        stall;
   int          m_popped;
   bit          m_init = 1'b0;
`endif

   line_buf_ring_ctrl #(.LINES_AMOUNT(N), .IDX_WIDTH(IW)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .ring  (bus)
`ifdef LINE_BUF_RING_CTRL_STAT_EN
      ,
      .lines_popped_o (lines_popped),
      .stall_o        (stall)
`endif
   );

   always #5 clk = ~clk;

   // Model: lines received this frame, write/oldest row numbers, and phase flags.
   int m_lines, m_wr, m_oldest;
   bit m_pending, m_reading, m_pop, m_flush;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_step(input bit r, input bit s, input bit e, input bit rdy,
                             input bit oe, input logic [N-1:0] emp);
      bit nxt_pop, nxt_flush;
      nxt_pop   = 1'b0;
      nxt_flush = 1'b0;
      if (r || s) begin
         m_lines   = (s && e) ? 1 : 0;
         m_wr      = (s && e) ? 1 : 0;
         m_pending = s && e;
         m_oldest  = 0;
         m_reading = 1'b0;
`ifdef LINE_BUF_RING_CTRL_STAT_EN
         m_popped  = 0;
         m_init    = 1'b1;
`endif
      end else begin
         if (m_flush)
            m_oldest = (m_oldest + 1) % N;
         else if (m_reading) begin
            if (oe) begin
               m_reading = 1'b0;
               nxt_flush = 1'b1;
            end
         end else if (m_lines >= N && m_pending && rdy && emp == '0) begin
            nxt_pop   = 1'b1;
            m_reading = 1'b1;
            m_pending = 1'b0;
`ifdef LINE_BUF_RING_CTRL_STAT_EN
            if (m_popped < 65535) m_popped++;
`endif
         end
         if (e) begin
            if (m_lines < N) m_lines++;
            m_pending = 1'b1;
            m_wr      = (m_wr + 1) % N;
         end
      end
      m_pop   = nxt_pop;
      m_flush = nxt_flush;
   endtask

   task automatic compare_all();
      check("wr_sel",      32'(bus.wr_sel_o),      32'(1) << m_wr);
      check("pop_line",    32'(bus.pop_line_o),    m_pop ? ALL1 : 0);
      check("flush_line",  32'(bus.flush_line_o),  m_flush ? (32'(1) << m_oldest) : 0);
      check("oldest_idx",  32'(bus.oldest_idx_o),  m_oldest);
      check("window_busy", 32'(bus.window_busy_o), 32'(m_reading));
`ifdef LINE_BUF_RING_CTRL_STAT_EN
      check("lines_popped", 32'(lines_popped), m_popped);
`endif
   endtask

   // Drive one cycle of inputs, advance the model on the edge, compare after it.
   task automatic apply(input bit r, input bit s, input bit e, input bit rdy,
                        input bit oe, input logic [N-1:0] emp);
      rst             = r;
      bus.in_sof_i    = s;
      bus.in_eol_i    = e;
      bus.out_ready_i = rdy;
      bus.out_eol_i   = oe;
      bus.empty_i     = emp;
`ifdef LINE_BUF_RING_CTRL_STAT_EN
      #1;
      if (m_init)
         check("stall", 32'(stall),
               32'(m_lines >= N && !m_reading && !m_flush && m_pending && !rdy));
`endif
      @(posedge clk);
      model_step(r, s, e, rdy, oe, emp);
      #1;
      compare_all();
   endtask

   task automatic send_line(input bit sof, input bit rdy);
      for (int i = 0; i < LINE_PX; i++)
         apply(1'b0, sof && i == 0, i == LINE_PX - 1, rdy, 1'b0, '0);
   endtask

   initial begin
      m_lines = 0; m_wr = 0; m_oldest = 0;
      m_pending = 0; m_reading = 0; m_pop = 0; m_flush = 0;

      // Reset
      repeat (3) apply(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
      check("rst_wr_sel", 32'(bus.wr_sel_o), 32'b001);
      check("rst_oldest", 32'(bus.oldest_idx_o), 0);
      check("rst_pop",    32'(bus.pop_line_o), 0);
      check("rst_flush",  32'(bus.flush_line_o), 0);
      apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);

      // Fill the window: SOF + 3 lines
      send_line(1'b1, 1'b1);
      check("wr_sel_l1", 32'(bus.wr_sel_o), 32'b010);
      send_line(1'b0, 1'b1);
      check("wr_sel_l2", 32'(bus.wr_sel_o), 32'b100);
      send_line(1'b0, 1'b1);
      check("wr_sel_l3", 32'(bus.wr_sel_o), 32'b001);
      check("no_pop_at_eol3", 32'(bus.pop_line_o), 0);
      apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
      check("pop_after_eol3", 32'(bus.pop_line_o), 32'b111);
      apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
      check("pop_one_cycle", 32'(bus.pop_line_o), 0);
      check("busy_in_read", 32'(bus.window_busy_o), 1);

      // Window read ends, oldest row flushed, 4th line triggers next pop
      repeat (5) apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
      apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, '0);
      check("flush_mask", 32'(bus.flush_line_o), 32'b001);
      apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
      check("flush_one_cycle", 32'(bus.flush_line_o), 0);
      check("oldest_inc", 32'(bus.oldest_idx_o), 1);
      send_line(1'b0, 1'b1);
      apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
      check("pop_after_eol4", 32'(bus.pop_line_o), 32'b111);

      // Downstream not ready for 20 cycles
      repeat (3) apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
      apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, '0);
      apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
      send_line(1'b0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
         check("stall_no_pop", 32'(bus.pop_line_o), 0);
`ifdef LINE_BUF_RING_CTRL_STAT_EN
         check("stall_flag", 32'(stall), 1);
`endif
      end
      apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
      check("pop_on_ready", 32'(bus.pop_line_o), 32'b111);

      // SOF during READ, then a stray out_eol
      apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
      apply(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, '0);
      check("sof_read_wr_sel", 32'(bus.wr_sel_o), 32'b001);
      check("sof_read_oldest", 32'(bus.oldest_idx_o), 0);
      check("sof_read_busy",   32'(bus.window_busy_o), 0);
      apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, '0);
      check("oeol_ignored", 32'(bus.flush_line_o), 0);

      // One-pixel line: SOF and EOL together
      apply(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, '0);
      check("one_px_wr_sel", 32'(bus.wr_sel_o), 32'b010);
      send_line(1'b0, 1'b1);
      send_line(1'b0, 1'b1);
      apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
      check("one_px_fill", 32'(bus.pop_line_o), 32'b111);

      // Random traffic including mid-frame SOF and reset
      for (int i = 0; i < 3000; i++) begin
         apply($urandom_range(0, 199) == 0,
               $urandom_range(0, 59) == 0,
               $urandom_range(0, 5) == 0,
               $urandom_range(0, 3) != 0,
               $urandom_range(0, 4) == 0,
               ($urandom_range(0, 4) == 0) ? N'($urandom) : '0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
